// File: rtl/sparhixcel_pkg.sv
// Shared types and default widths for the SparHiXcel load sequencer slice.
package sparhixcel_pkg;

  localparam int BUS_WIDTH_DEF       = 72;
  localparam int FEAT_DATA_WIDTH_DEF = 72;
  localparam int WGT_DATA_WIDTH_DEF  = 72;
  localparam int SIG_DATA_WIDTH_DEF  = 63;
  localparam int FEAT_ADDR_WIDTH_DEF = 16;
  localparam int SIG_ADDR_WIDTH_DEF  = 10;
  localparam int RUN_CNT_WIDTH_DEF   = 20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_SIG  = 3'd1,
    LD_WGT  = 3'd2,
    LD_FEAT = 3'd3,
    RUN     = 3'd4,
    FINISH  = 3'd5
  } load_state_t;

  // Returns the first section after 'from' whose count is nonzero.
  // Sections are ordered LD_SIG, LD_WGT, LD_FEAT, RUN; FINISH if all are empty.
  function automatic load_state_t first_section(input load_state_t from,
                                                input logic sig_nz,
                                                input logic wgt_nz,
                                                input logic feat_nz,
                                                input logic run_nz);
    load_state_t nxt;
    nxt = FINISH;
    if (run_nz  && (from inside {IDLE, LD_SIG, LD_WGT, LD_FEAT})) nxt = RUN;
    if (feat_nz && (from inside {IDLE, LD_SIG, LD_WGT}))          nxt = LD_FEAT;
    if (wgt_nz  && (from inside {IDLE, LD_SIG}))                  nxt = LD_WGT;
    if (sig_nz  && (from == IDLE))                                nxt = LD_SIG;
    return nxt;
  endfunction

endpackage

// File: rtl/sparhixcel_load_sequencer_wr_port_reg.sv
// Registered write stage for one memory port: strobe, address and data are
// captured on the handshake cycle and presented one cycle later.
module sparhixcel_wr_port_reg #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 72
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ld_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  wr_ld_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o
);

  // Strobe follows the request each cycle; address/data hold between writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ld_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      wr_ld_o <= ld_i;
      if (ld_i) begin
        wr_addr_o <= addr_i;
        wr_data_o <= data_i;
      end
    end
  end

endmodule

// File: rtl/sparhixcel_load_sequencer.sv
// SparHiXcel front-end load sequencer: takes one descriptor, routes the host
// stream into signal ROM, weight memory and feature memory, then releases the
// accelerator general reset for a programmed number of cycles.
// Optional running XOR checksum of the stream: SPARHIXCEL_LOAD_CHECKSUM_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready is a pure function of the FSM state and never depends on
// valid, and a source may raise or drop valid in any cycle.
module sparhixcel_load_sequencer
  import sparhixcel_pkg::*;
#(
  parameter int BUS_WIDTH       = BUS_WIDTH_DEF,
  parameter int FEAT_DATA_WIDTH = FEAT_DATA_WIDTH_DEF,
  parameter int WGT_DATA_WIDTH  = WGT_DATA_WIDTH_DEF,
  parameter int SIG_DATA_WIDTH  = SIG_DATA_WIDTH_DEF,
  parameter int FEAT_ADDR_WIDTH = FEAT_ADDR_WIDTH_DEF,
  parameter int SIG_ADDR_WIDTH  = SIG_ADDR_WIDTH_DEF,
  parameter int RUN_CNT_WIDTH   = RUN_CNT_WIDTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [SIG_ADDR_WIDTH-1:0]  cfg_n_sig_i,
  input  logic [SIG_ADDR_WIDTH-1:0]  cfg_n_wgt_i,
  input  logic [FEAT_ADDR_WIDTH-1:0] cfg_n_feat_i,
  input  logic [RUN_CNT_WIDTH-1:0]   cfg_run_cycles_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [BUS_WIDTH-1:0]       s_data_i,
  input  logic                       abort_i,
  output logic                       wr_rom_signals_ld_o,
  output logic [SIG_ADDR_WIDTH-1:0]  wr_addrs_rom_signal_o,
  output logic [SIG_DATA_WIDTH-1:0]  rom_signals_data_o,
  output logic                       wr_mem2_ld_o,
  output logic [SIG_ADDR_WIDTH-1:0]  wr_addrs_mem2_o,
  output logic [WGT_DATA_WIDTH-1:0]  mem2_data_o,
  output logic                       wr_mem_ld_o,
  output logic [FEAT_ADDR_WIDTH-1:0] wr_addrs_mem_o,
  output logic [FEAT_DATA_WIDTH-1:0] mem_data_o,
  output logic [FEAT_ADDR_WIDTH-1:0] end_addr_in_feature_o,
`ifdef SPARHIXCEL_LOAD_CHECKSUM_EN
  output logic [BUS_WIDTH-1:0]       chk_o,
`endif
  output logic                       array_rst_o,
  output logic                       busy_o,
  output logic                       done_o,
  output load_state_t                state_o
);

  // One word counter serves all sections, so it is as wide as the widest address.
  localparam int CNT_W = (FEAT_ADDR_WIDTH > SIG_ADDR_WIDTH) ? FEAT_ADDR_WIDTH : SIG_ADDR_WIDTH;

  load_state_t state_q, state_d;

  logic [CNT_W-1:0]           wcnt_q;
  logic [RUN_CNT_WIDTH-1:0]   rcnt_q;
  logic [SIG_ADDR_WIDTH-1:0]  n_sig_q, n_wgt_q;
  logic [FEAT_ADDR_WIDTH-1:0] n_feat_q;
  logic [RUN_CNT_WIDTH-1:0]   n_run_q;

  logic             cfg_fire, s_fire, abort_act, last_word, run_last;
  logic [CNT_W-1:0] sec_len;
  logic             ld_sig, ld_wgt, ld_feat;

  assign cfg_fire  = cfg_valid_i & cfg_ready_o;
  assign s_fire    = s_valid_i & s_ready_o;
  assign abort_act = abort_i & (state_q != IDLE);
  assign last_word = (wcnt_q == (sec_len - CNT_W'(1)));
  assign run_last  = (rcnt_q == (n_run_q - RUN_CNT_WIDTH'(1)));
  assign state_o   = state_q;

  // Length of the section currently being loaded.
  always_comb begin
    sec_len = '0;
    case (state_q)
      LD_SIG:  sec_len = CNT_W'(n_sig_q);
      LD_WGT:  sec_len = CNT_W'(n_wgt_q);
      LD_FEAT: sec_len = CNT_W'(n_feat_q);
      default: sec_len = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides any advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cfg_fire)
              state_d = first_section(IDLE, |cfg_n_sig_i, |cfg_n_wgt_i,
                                      |cfg_n_feat_i, |cfg_run_cycles_i);
      LD_SIG, LD_WGT, LD_FEAT:
            if (s_fire && last_word)
              state_d = first_section(state_q, |n_sig_q, |n_wgt_q,
                                      |n_feat_q, |n_run_q);
      RUN:    if (run_last) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_act) state_d = IDLE;
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    cfg_ready_o = (state_q == IDLE);
    s_ready_o   = (state_q == LD_SIG) || (state_q == LD_WGT) || (state_q == LD_FEAT);
    array_rst_o = (state_q != RUN);
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == FINISH);
  end

  // Descriptor capture plus word and run counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_sig_q               <= '0;
      n_wgt_q               <= '0;
      n_feat_q              <= '0;
      n_run_q               <= '0;
      wcnt_q                <= '0;
      rcnt_q                <= '0;
      end_addr_in_feature_o <= '0;
    end else begin
      if (cfg_fire) begin
        n_sig_q               <= cfg_n_sig_i;
        n_wgt_q               <= cfg_n_wgt_i;
        n_feat_q              <= cfg_n_feat_i;
        n_run_q               <= cfg_run_cycles_i;
        wcnt_q                <= '0;
        rcnt_q                <= '0;
        end_addr_in_feature_o <= (cfg_n_feat_i == '0) ? '0
                                 : (cfg_n_feat_i - FEAT_ADDR_WIDTH'(1));
      end else if (abort_act) begin
        wcnt_q <= '0;
        rcnt_q <= '0;
      end else if (s_fire) begin
        wcnt_q <= last_word ? '0 : (wcnt_q + CNT_W'(1));
      end else if (state_q == RUN) begin
        rcnt_q <= run_last ? '0 : (rcnt_q + RUN_CNT_WIDTH'(1));
      end
    end
  end

`ifdef SPARHIXCEL_LOAD_CHECKSUM_EN
  // Running XOR of accepted stream words, restarted by each descriptor.
  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_fire) chk_o <= '0;
    else if (s_fire)       chk_o <= chk_o ^ s_data_i;
  end
`endif

  assign ld_sig  = s_fire && (state_q == LD_SIG);
  assign ld_wgt  = s_fire && (state_q == LD_WGT);
  assign ld_feat = s_fire && (state_q == LD_FEAT);

  sparhixcel_wr_port_reg #(.ADDR_WIDTH(SIG_ADDR_WIDTH), .DATA_WIDTH(SIG_DATA_WIDTH)) u_sig_port (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ld_i      (ld_sig),
    .addr_i    (wcnt_q[SIG_ADDR_WIDTH-1:0]),
    .data_i    (s_data_i[SIG_DATA_WIDTH-1:0]),
    .wr_ld_o   (wr_rom_signals_ld_o),
    .wr_addr_o (wr_addrs_rom_signal_o),
    .wr_data_o (rom_signals_data_o)
  );

  sparhixcel_wr_port_reg #(.ADDR_WIDTH(SIG_ADDR_WIDTH), .DATA_WIDTH(WGT_DATA_WIDTH)) u_wgt_port (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ld_i      (ld_wgt),
    .addr_i    (wcnt_q[SIG_ADDR_WIDTH-1:0]),
    .data_i    (s_data_i[WGT_DATA_WIDTH-1:0]),
    .wr_ld_o   (wr_mem2_ld_o),
    .wr_addr_o (wr_addrs_mem2_o),
    .wr_data_o (mem2_data_o)
  );

  sparhixcel_wr_port_reg #(.ADDR_WIDTH(FEAT_ADDR_WIDTH), .DATA_WIDTH(FEAT_DATA_WIDTH)) u_feat_port (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ld_i      (ld_feat),
    .addr_i    (wcnt_q[FEAT_ADDR_WIDTH-1:0]),
    .data_i    (s_data_i[FEAT_DATA_WIDTH-1:0]),
    .wr_ld_o   (wr_mem_ld_o),
    .wr_addr_o (wr_addrs_mem_o),
    .wr_data_o (mem_data_o)
  );

endmodule

// File: tb/tb_sparhixcel_load_sequencer.sv
// Self-checking bench for sparhixcel_load_sequencer: random jobs against a
// word-list model of where each accepted stream word must land.
module tb_sparhixcel_load_sequencer;
  import sparhixcel_pkg::*;

  localparam int BW = 72, FDW = 72, WDW = 72, SDW = 63, FAW = 16, SAW = 10, RCW = 20;

  // ---------------- clock / reset / DUT ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic           cfg_valid_i, cfg_ready_o;
  logic [SAW-1:0] cfg_n_sig_i, cfg_n_wgt_i;
  logic [FAW-1:0] cfg_n_feat_i;
  logic [RCW-1:0] cfg_run_cycles_i;
  logic           s_valid_i, s_ready_o, abort_i;
  logic [BW-1:0]  s_data_i;
  logic           wr_rom_signals_ld_o, wr_mem2_ld_o, wr_mem_ld_o;
  logic [SAW-1:0] wr_addrs_rom_signal_o, wr_addrs_mem2_o;
  logic [FAW-1:0] wr_addrs_mem_o, end_addr_in_feature_o;
  logic [SDW-1:0] rom_signals_data_o;
  logic [WDW-1:0] mem2_data_o;
  logic [FDW-1:0] mem_data_o;
  logic           array_rst_o, busy_o, done_o;
  load_state_t    state_o;
`ifdef SPARHIXCEL_LOAD_CHECKSUM_EN
  logic [BW-1:0]  chk_o;
`endif

  sparhixcel_load_sequencer #(
    .BUS_WIDTH(BW), .FEAT_DATA_WIDTH(FDW), .WGT_DATA_WIDTH(WDW), .SIG_DATA_WIDTH(SDW),
    .FEAT_ADDR_WIDTH(FAW), .SIG_ADDR_WIDTH(SAW), .RUN_CNT_WIDTH(RCW)
  ) dut (
`ifdef SPARHIXCEL_LOAD_CHECKSUM_EN
    .chk_o                 (chk_o),
`endif
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .cfg_valid_i           (cfg_valid_i),
    .cfg_ready_o           (cfg_ready_o),
    .cfg_n_sig_i           (cfg_n_sig_i),
    .cfg_n_wgt_i           (cfg_n_wgt_i),
    .cfg_n_feat_i          (cfg_n_feat_i),
    .cfg_run_cycles_i      (cfg_run_cycles_i),
    .s_valid_i             (s_valid_i),
    .s_ready_o             (s_ready_o),
    .s_data_i              (s_data_i),
    .abort_i               (abort_i),
    .wr_rom_signals_ld_o   (wr_rom_signals_ld_o),
    .wr_addrs_rom_signal_o (wr_addrs_rom_signal_o),
    .rom_signals_data_o    (rom_signals_data_o),
    .wr_mem2_ld_o          (wr_mem2_ld_o),
    .wr_addrs_mem2_o       (wr_addrs_mem2_o),
    .mem2_data_o           (mem2_data_o),
    .wr_mem_ld_o           (wr_mem_ld_o),
    .wr_addrs_mem_o        (wr_addrs_mem_o),
    .mem_data_o            (mem_data_o),
    .end_addr_in_feature_o (end_addr_in_feature_o),
    .array_rst_o           (array_rst_o),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .state_o               (state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [89:0] exp_q[$];   // {mem id (1 sig, 2 wgt, 3 feat), addr[15:0], data[71:0]}
  logic [71:0] word_q[$];  // preset stream words; random words once empty
  int rst_low_cnt = 0;
  int done_cnt    = 0;
  bit mon_en      = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic score(input logic [89:0] got);
    if (exp_q.size() == 0) check("unexpected_strobe", 128'(got), 128'(0));
    else                   check("write", 128'(got), 128'(exp_q.pop_front()));
  endtask

  // Monitor: every strobe must be the next expected write; tally run/done cycles.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if ((int'(wr_rom_signals_ld_o) + int'(wr_mem2_ld_o) + int'(wr_mem_ld_o)) > 1)
        check("one_strobe", 128'({wr_rom_signals_ld_o, wr_mem2_ld_o, wr_mem_ld_o}), 128'(0));
      if (wr_rom_signals_ld_o) score({2'd1, 16'(wr_addrs_rom_signal_o), 72'(rom_signals_data_o)});
      if (wr_mem2_ld_o)        score({2'd2, 16'(wr_addrs_mem2_o), 72'(mem2_data_o)});
      if (wr_mem_ld_o)         score({2'd3, 16'(wr_addrs_mem_o), 72'(mem_data_o)});
      rst_low_cnt += int'(!array_rst_o);
      done_cnt    += int'(done_o);
    end
  end

  // ---------------- reference model ----------------
  // Word k of the stream goes to the k-th slot of the concatenated section list.
  function automatic logic [89:0] model_write(input int k, input logic [71:0] w,
                                              input int ns, input int nw);
    if (k < ns)           return {2'd1, 16'(k), 72'(w[62:0])};
    else if (k < ns + nw) return {2'd2, 16'(k - ns), w};
    else                  return {2'd3, 16'(k - ns - nw), w};
  endfunction

  function automatic logic [71:0] next_word();
    if (word_q.size() != 0) return word_q.pop_front();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_cfg(input int ns, input int nw, input int nf, input int rc);
    @(posedge clk_i); #1;
    check("cfg_ready_idle", 128'(cfg_ready_o), 128'(1));
    cfg_valid_i      = 1'b1;
    cfg_n_sig_i      = SAW'(ns);
    cfg_n_wgt_i      = SAW'(nw);
    cfg_n_feat_i     = FAW'(nf);
    cfg_run_cycles_i = RCW'(rc);
    @(posedge clk_i); #1;
    cfg_valid_i      = 1'b0;
    cfg_n_sig_i      = SAW'($urandom);
    cfg_n_wgt_i      = SAW'($urandom);
    cfg_n_feat_i     = FAW'($urandom);
    cfg_run_cycles_i = RCW'($urandom);
  endtask

  // stall: 0 = always valid, 1 = valid every other cycle, 2 = random valid.
  // abort_at > 0: abort right after that many words were accepted.
  task automatic do_job(input int ns, input int nw, input int nf, input int rc,
                        input int stall, input int abort_at);
    int total, acc, cyc, lat;
    logic [71:0] w, xsum;
    bit aborted;
    total = ns + nw + nf; acc = 0; cyc = 0; xsum = '0; aborted = 1'b0;
    send_cfg(ns, nw, nf, rc);
    rst_low_cnt = 0; done_cnt = 0;
    w = next_word();
    while (acc < total && cyc < 4000) begin
      s_valid_i = (stall == 0) ? 1'b1 : (stall == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      s_data_i  = w;
      @(negedge clk_i);
      if (s_valid_i) begin
        check("s_ready_load", 128'(s_ready_o), 128'(1));
        if (s_ready_o) begin
          exp_q.push_back(model_write(acc, w, ns, nw));
          xsum ^= w;
          acc++;
          w = next_word();
        end
      end
      @(posedge clk_i); #1;
      cyc++;
      if (abort_at > 0 && acc == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    s_valid_i = 1'b0;
    if (!aborted) check("load_words", 128'(acc), 128'(total));
    if (aborted) begin
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      check("abort_idle_busy", 128'(busy_o), 128'(0));
      check("abort_array_rst", 128'(array_rst_o), 128'(1));
      repeat (rc + 3) @(posedge clk_i);
      #1;
      check("abort_no_done", 128'(done_cnt), 128'(0));
      check("abort_no_run", 128'(rst_low_cnt), 128'(0));
      check("abort_cfg_ready", 128'(cfg_ready_o), 128'(1));
    end else begin
      lat = 0;
      while (lat < rc + 20) begin
        @(negedge clk_i);
        lat++;
        if (done_o) break;
      end
      check("done_latency", 128'(lat), 128'(rc + 1));
      @(posedge clk_i); #1;
      check("done_pulses", 128'(done_cnt), 128'(1));
      check("run_low_cycles", 128'(rst_low_cnt), 128'(rc));
      check("end_addr", 128'(end_addr_in_feature_o), 128'((nf == 0) ? 0 : nf - 1));
      check("idle_after_job", 128'({busy_o, array_rst_o, done_o}), 128'(3'b010));
    end
    check("writes_drained", 128'(exp_q.size()), 128'(0));
`ifdef SPARHIXCEL_LOAD_CHECKSUM_EN
    check("checksum", 128'(chk_o), 128'(xsum));
`endif
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i = 1'b1; cfg_valid_i = 1'b0; s_valid_i = 1'b0; abort_i = 1'b0;
    cfg_n_sig_i = '0; cfg_n_wgt_i = '0; cfg_n_feat_i = '0; cfg_run_cycles_i = '0;
    s_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_array_rst", 128'(array_rst_o), 128'(1));
    check("rst_strobes", 128'({wr_rom_signals_ld_o, wr_mem2_ld_o, wr_mem_ld_o}), 128'(0));
    check("rst_cfg_ready", 128'(cfg_ready_o), 128'(1));
    check("rst_busy_done_sready", 128'({busy_o, done_o, s_ready_o}), 128'(0));
    check("rst_end_addr", 128'(end_addr_in_feature_o), 128'(0));
    rst_i  = 1'b0;
    mon_en = 1'b1;

    // Full job, words 1..9 without stalls.
    for (int i = 1; i <= 9; i++) word_q.push_back(72'(i));
    do_job(2, 3, 4, 5, 0, 0);
    // Empty weight section with valid toggling.
    do_job(3, 0, 4, 2, 1, 0);
    // Zero run length: array reset never released.
    do_job(2, 2, 2, 0, 0, 0);
    // Abort after the 2nd feature word.
    do_job(1, 2, 4, 3, 0, 5);
    // Everything empty.
    do_job(0, 0, 0, 0, 0, 0);
    do_job(0, 0, 0, 4, 2, 0);

    // Random jobs.
    for (int j = 0; j < 10; j++)
      do_job($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
             $urandom_range(0, 6), $urandom_range(0, 2), 0);
    do_job(3, 3, 3, 4, 2, $urandom_range(1, 8));

    // Reset in the middle of a load drops the word taken in the reset cycle.
    send_cfg(4, 0, 0, 2);
    for (int k = 0; k < 2; k++) begin
      s_valid_i = 1'b1;
      s_data_i  = 72'(k + 100);
      exp_q.push_back(model_write(k, s_data_i, 4, 0));
      @(posedge clk_i); #1;
    end
    s_data_i = 72'h55;
    rst_i    = 1'b1;
    @(posedge clk_i); #1;
    rst_i     = 1'b0;
    s_valid_i = 1'b0;
    @(negedge clk_i);
    check("midrst_strobes", 128'({wr_rom_signals_ld_o, wr_mem2_ld_o, wr_mem_ld_o}), 128'(0));
    check("midrst_state", 128'({busy_o, array_rst_o, cfg_ready_o, s_ready_o}), 128'(4'b0110));
    check("midrst_drained", 128'(exp_q.size()), 128'(0));
`ifdef SPARHIXCEL_LOAD_CHECKSUM_EN
    check("midrst_chk", 128'(chk_o), 128'(0));
    word_q.push_back(72'h0F);
    word_q.push_back(72'hF0);
    word_q.push_back(72'h33);
    do_job(3, 0, 0, 1, 0, 0);
    check("chk_fixed", 128'(chk_o), 128'(72'hCC));
`endif
    do_job(2, 1, 3, 2, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sparhixcel_load_sequencer.md
Name: sparhixcel_load_sequencer

Overview:
- Front-end controller for the SparHiXcel accelerator top level.
- Accepts one configuration descriptor, then one host word stream. Routes the stream into the signal ROM, the weight memory and the input-feature memory, in that order, generating write addresses and write strobes.
- Then releases the accelerator's general reset for a programmed number of cycles and re-asserts it.
- Sits between the host/DMA and the top-level memory write ports and general_rst_i.

Parameters:
- BUS_WIDTH, 72, host data width; must be >= every memory data width (9 rows x 8 bit).
- FEAT_DATA_WIDTH, 72, input-feature memory word width.
- WGT_DATA_WIDTH, 72, weight memory word width.
- SIG_DATA_WIDTH, 63, signal ROM word width.
- FEAT_ADDR_WIDTH, 16, input-feature memory address width.
- SIG_ADDR_WIDTH, 10, weight memory and signal ROM address width.
- RUN_CNT_WIDTH, 20, width of the run-cycle counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cfg_valid_i  in  1  descriptor valid.
- cfg_ready_o  out  1  descriptor accepted when cfg_valid_i and cfg_ready_o are both high.
- cfg_n_sig_i  in  SIG_ADDR_WIDTH  number of signal ROM words.
- cfg_n_wgt_i  in  SIG_ADDR_WIDTH  number of weight words.
- cfg_n_feat_i  in  FEAT_ADDR_WIDTH  number of feature words.
- cfg_run_cycles_i  in  RUN_CNT_WIDTH  cycles that general reset stays released.
- s_valid_i  in  1  stream word valid.
- s_ready_o  out  1  stream ready.
- s_data_i  in  BUS_WIDTH  stream word.
- abort_i  in  1  abandons the current job.
- wr_rom_signals_ld_o, wr_addrs_rom_signal_o[SIG_ADDR_WIDTH], rom_signals_data_o[SIG_DATA_WIDTH]  out  signal ROM write port.
- wr_mem2_ld_o, wr_addrs_mem2_o[SIG_ADDR_WIDTH], mem2_data_o[WGT_DATA_WIDTH]  out  weight memory write port.
- wr_mem_ld_o, wr_addrs_mem_o[FEAT_ADDR_WIDTH], mem_data_o[FEAT_DATA_WIDTH]  out  feature memory write port.
- end_addr_in_feature_o  out  FEAT_ADDR_WIDTH  last feature address.
- array_rst_o  out  1  drives the accelerator's general_rst_i.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset values:
  - State IDLE.
  - All *_ld_o = 0; all address and data outputs = 0.
  - end_addr_in_feature_o = 0.
  - array_rst_o = 1; busy_o = 0; done_o = 0; cfg_ready_o = 1; s_ready_o = 0.
- FSM states: IDLE, LD_SIG, LD_WGT, LD_FEAT, RUN, FINISH.
- IDLE:
  - cfg_ready_o = 1.
  - A descriptor handshake latches all cfg_* fields and clears the word counter.
  - Next state is the first of LD_SIG, LD_WGT, LD_FEAT, RUN whose count is nonzero.
  - end_addr_in_feature_o is set to cfg_n_feat_i - 1, or to 0 if cfg_n_feat_i = 0.
- Outside IDLE, cfg_ready_o = 0 and cfg_valid_i is ignored.
- LD_* states:
  - s_ready_o = 1.
  - Each accepted word (s_valid_i and s_ready_o both high) produces, on the next cycle, exactly one write strobe for that memory.
  - The write address equals the counter value at acceptance; data is the low bits of the accepted word. Latency is 1 cycle and registered.
  - No strobe is produced without a handshake; the write ports are idle when s_valid_i = 0.
  - The counter increments per accepted word.
  - On the last word (counter = n - 1), the counter clears and the state advances in the same cycle to the next nonzero section; zero-length sections are skipped.
  - At most one write strobe is high per cycle.
- RUN:
  - array_rst_o = 0 and s_ready_o = 0.
  - The run counter counts from 0. At cfg_run_cycles_i - 1 the state goes to FINISH.
  - cfg_run_cycles_i = 0 skips RUN entirely: FINISH follows directly, and array_rst_o is never deasserted.
- FINISH (one cycle): array_rst_o = 1, done_o = 1, then IDLE.
- array_rst_o is 1 in every state except RUN.
- abort_i:
  - In any non-IDLE state, the next state is IDLE and counters clear.
  - array_rst_o = 1 the next cycle, done_o is not pulsed, and no further write strobes occur.
  - An abort in the same cycle as the last accepted word still produces that word's write strobe on the next cycle; abort wins over the state advance.
  - abort_i in IDLE has no effect.
- rst_i mid-operation: outputs take their reset values on the next edge, and any pending strobe is dropped.
- All counters are unsigned; no wrap-around is possible because each count is bounded by its port width.

Optional Feature:
- Macro: SPARHIXCEL_LOAD_CHECKSUM_EN.
- When defined:
  - Extra output chk_o[BUS_WIDTH] holds the running XOR of every accepted stream word, zero-extended.
  - chk_o is cleared on the descriptor handshake, or on rst_i.
  - chk_o holds its value through RUN, FINISH and IDLE, until the next descriptor.
- When undefined: no chk_o port and no checksum logic.

Decomposition:
- Package sparhixcel_pkg holds:
  - the state enum load_state_t;
  - default width constants: 72/63 data widths, 16/10 address widths, 20 for the run counter.
- One sub-module, sparhixcel_wr_port_reg: the registered strobe/address/data stage for one memory, instantiated three times.

Test Plan:
- Reset: hold rst_i high for 3 cycles -> array_rst_o = 1, all *_ld_o = 0, cfg_ready_o = 1, busy_o = 0.
- Full job:
  - Stimulus: n_sig = 2, n_wgt = 3, n_feat = 4, run = 5, stream words 1..9 with no stalls.
  - Expected signal ROM writes: addresses 0,1 with data 1,2.
  - Expected weight writes: addresses 0..2 with data 3..5.
  - Expected feature writes: addresses 0..3 with data 6..9.
  - Then end_addr_in_feature_o = 3, array_rst_o low for exactly 5 cycles, done_o high for 1 cycle.
- Zero-length section: n_wgt = 0, with s_valid_i toggling every other cycle -> no wr_mem2_ld_o ever; feature writes follow the signal writes; one strobe per handshake.
- run = 0: after the load completes, done_o pulses and array_rst_o never drops.
- Abort: assert abort_i after the 2nd feature word of n_feat = 4 -> exactly 2 feature strobes, IDLE on the next cycle, no done_o, array_rst_o = 1.
- Checksum (macro defined): words 0x0F, 0xF0, 0x33 -> chk_o = 0xCC after the last word.
